serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial addition controller that time-multiplexes one 1-bit full adder cell across WIDTH bit positions to add two WIDTH-bit operands plus carry-in. It sits between a requester issuing start/operand handshakes and the full adder datapath cell. It sequences the cell LSB-first, holds the running carry in a flip-flop, and assembles the result in a shift register. Results are presented on registered outputs with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op_a  input  WIDTH  operand A; captured on the accepting edge.
- op_b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result register; holds the last completed result.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Single full adder cell instance with ports X1, X2, Cin, S, Cout.
- X1 = a_sh[0], X2 = b_sh[0], Cin = carry_q.
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, load a_sh<=op_a, b_sh<=op_b, carry_q<=cin, cnt<=0, go to RUN. With start=0, stay in IDLE.
- RUN, each edge:
  - a_sh and b_sh shift right by 1.
  - S shifts into the MSB of s_sh; s_sh shifts right.
  - carry_q<=Cout; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1, also capture carry_q into cmsb_q (carry into the MSB).
  - Transfer sum<=final s_sh, cout<=Cout, ovf<=cmsb_q^Cout, then go to DONE.
- DONE: done=1 for exactly this cycle; unconditionally go to IDLE on the next edge.
- start is ignored in RUN and DONE. It is not queued. Operands may change freely while busy.
- sum, cout and ovf change only on the RUN->DONE edge. They are stable during a following RUN.
- Arithmetic: {cout,sum} = op_a + op_b + cin, modulo 2^(WIDTH+1). cnt width is clog2(WIDTH)+1 bits.
- No abort input exists. rst is the only way to cancel an operation.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0. Shift registers, carry_q, cmsb_q and cnt are all 0.
- Reset mid-RUN: the operation is discarded. Outputs immediately return to reset values and no done pulse is produced.
- Edge 0 is the edge that samples start=1 in IDLE:
  - busy rises after edge 0.
  - Bit i is computed between edges i and i+1.
  - The result is registered on edge WIDTH, with done high for the cycle following edge WIDTH.
  - IDLE is reached after edge WIDTH+1.
- Latency from start to done is WIDTH cycles. Minimum issue interval is WIDTH+2 cycles.
- start held high continuously yields back-to-back operations every WIDTH+2 cycles.
- busy and done are never high simultaneously.
- Release of rst is synchronous to clk externally. The block samples start from the first edge after release.

## Test plan
- Reset: assert rst with start=1 -> busy=0, done=0, sum=0x00, cout=0, ovf=0. After release, IDLE accepts the next start.
- WIDTH=8, op_a=0x7F, op_b=0x01, cin=0:
  - busy is high for 8 cycles after the accepting edge.
  - done pulses exactly 8 cycles after acceptance.
  - sum=0x80, cout=0, ovf=1.
- Carry extremes, WIDTH=8:
  - 0xFF+0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
  - 0xFF+0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
  - 0x80+0x80, cin=0 -> sum=0x00, cout=1, ovf=1.
- Busy protection: start 0x12+0x34, then pulse start with 0xAA/0x55 at cycle 3 -> the second request is ignored. Result sum=0x46, and only one done pulse occurs.
- Reset mid-operation: start 0x0F+0x01, assert rst at cycle 4 -> no done, sum=0x00. A new start of 0x01+0x01 then gives sum=0x02 at done.
- Randomized back-to-back with start held high, 1000 operations:
  - Each done matches op_a+op_b+cin from the reference model.
  - Done spacing is WIDTH+2 cycles.
  - sum is unchanged between consecutive done pulses.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: reuses one full adder cell LSB-first across WIDTH
// cycles, keeping the running carry in a flop and assembling the result in a shift register.

module full_adder (
  input  logic X1,
  input  logic X2,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S    = X1 ^ X2 ^ Cin;
  assign Cout = (X1 & X2) | (X1 & Cin) | (X2 & Cin);
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int unsigned     CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic             carry_q, carry_d, cmsb_q, cmsb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic             fa_s, fa_co;

  full_adder u_fa (
    .X1  (a_q[0]),
    .X2  (b_q[0]),
    .Cin (carry_q),
    .S   (fa_s),
    .Cout(fa_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        s_d     = {fa_s, s_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // carry_q here is the carry into the MSB; ovf uses it directly since cmsb_q updates on this same edge
          cmsb_d  = carry_q;
          sum_d   = {fa_s, s_q[WIDTH-1:1]};
          cout_d  = fa_co;
          ovf_d   = cmsb_d ^ fa_co;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed corner cases plus a randomized
// back-to-back run checked against an arithmetic reference model.

module tb_serial_adder_ctrl;
  localparam int unsigned W = 8;
  localparam int unsigned PERIOD = W + 2;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] last_sum;
  logic         last_cout, last_ovf;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned sum for {cout,sum}; overflow from the signed-range rule.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int unsigned u;
    int sa, sb, s;
    logic [W-1:0] r;
    logic co, ov;
    u  = int'(a) + int'(b) + int'(c);
    r  = W'(u);
    co = (u >= (1 << W));
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    s  = sa + sb + int'(c);
    ov = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
    return {ov, co, r};
  endfunction

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W+1:0] e;
    e = model(a, b, c);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; cin = c;
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    for (int i = 0; i < int'(W); i++) begin
      check({tag, ".busy"}, 32'(busy), 32'd1);
      check({tag, ".nodone"}, 32'(done), 32'd0);
      @(negedge clk);
    end
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    check({tag, ".sum"}, 32'(sum), 32'(e[W-1:0]));
    check({tag, ".cout"}, 32'(cout), 32'(e[W]));
    check({tag, ".ovf"}, 32'(ovf), 32'(e[W+1]));
    last_sum = e[W-1:0]; last_cout = e[W]; last_ovf = e[W+1];
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [W+1:0] pend;
    int dones;
    rst = 1'b1; start = 1'b1; op_a = 8'h5A; op_b = 8'h3C; cin = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.sum", 32'(sum), 32'd0);
    check("rst.cout", 32'(cout), 32'd0);
    check("rst.ovf", 32'(ovf), 32'd0);
    rst = 1'b0; start = 1'b0;

    do_op("p7f_01", 8'h7F, 8'h01, 1'b0);
    do_op("ff_01", 8'hFF, 8'h01, 1'b0);
    do_op("ff_ff_c", 8'hFF, 8'hFF, 1'b1);
    do_op("80_80", 8'h80, 8'h80, 1'b0);

    // Busy protection: second request mid-run must be dropped.
    @(negedge clk);
    start = 1'b1; op_a = 8'h12; op_b = 8'h34; cin = 1'b0;
    dones = 0;
    for (int i = 0; i < int'(W) + 4; i++) begin
      @(negedge clk);
      start = (i == 3);
      if (i == 3) begin op_a = 8'hAA; op_b = 8'h55; end
      if (done) begin
        dones++;
        check("busyprot.sum", 32'(sum), 32'h46);
      end
    end
    start = 1'b0;
    check("busyprot.dones", 32'(dones), 32'd1);
    last_sum = 8'h46; last_cout = 1'b0; last_ovf = 1'b0;

    // Reset mid-operation discards the result.
    @(negedge clk);
    start = 1'b1; op_a = 8'h0F; op_b = 8'h01; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.sum", 32'(sum), 32'd0);
    dones = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) dones++;
    end
    rst = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst.nodone", 32'(dones), 32'd0);
    check("midrst.sum_hold", 32'(sum), 32'd0);
    do_op("after_rst", 8'h01, 8'h01, 1'b0);

    // Randomized back-to-back with start held high.
    pend = '0;
    for (int cyc = 0; cyc < 1000 * int'(PERIOD); cyc++) begin
      int ph;
      op_a = $urandom; op_b = $urandom; cin = 1'($urandom);
      start = 1'b1;
      ph = cyc % int'(PERIOD);
      if (ph == 0) pend = model(op_a, op_b, cin);
      @(negedge clk);
      check("rnd.busy", 32'(busy), 32'(ph < int'(W)));
      if (ph == int'(W)) begin
        last_sum = pend[W-1:0]; last_cout = pend[W]; last_ovf = pend[W+1];
        check("rnd.done", 32'(done), 32'd1);
      end else begin
        check("rnd.nodone", 32'(done), 32'd0);
      end
      check("rnd.sum", 32'(sum), 32'(last_sum));
      check("rnd.cout", 32'(cout), 32'(last_cout));
      check("rnd.ovf", 32'(ovf), 32'(last_ovf));
    end
    start = 1'b0;
    repeat (PERIOD + 2) @(negedge clk);
    check("end.idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
